fp_round_pack: RTL and testbench
================================

Name: fp_round_pack

Overview:
- Consumer end of the normalizer output interface in the FP multiply/divide datapath.
- Accepts sign, 26-bit normalized mantissa (23 fraction + 3 guard bits), 10-bit biased exponent and special-case flags.
- Applies IEEE-754 rounding, handles exponent overflow/underflow and packs a single-precision word.
- 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MANT_W, 26, normalized mantissa width: fraction [25:3], G/R/S [2:0].
- EXP_W, 10, signed two's-complement biased exponent input width.

Ports:
- clk  input  1  clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes the whole pipeline.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept this cycle.
- sign_in  input  1  result sign.
- mant_in  input  MANT_W  normalized mantissa, hidden bit removed.
- exp_in  input  EXP_W  biased exponent, signed.
- is_nan, is_inf, is_zero  input  1 each  special-operand flags from upstream.
- rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- result  output  32  packed IEEE-754 single.
- flag_ovf, flag_unf, flag_inx  output  1 each  overflow, underflow, inexact.

Behaviour:
- Reset (arst_n=0, asynchronous): both stage valids=0, result=0, all flags=0, out_valid=0. Reset mid-operation discards in-flight data.
- Handshake:
  - Transfer in on in_valid & in_ready & en; transfer out on out_valid & out_ready.
  - Stage 2 advances when en & (~s2_valid | out_ready). Stage 1 advances when it is valid and stage 2 advances.
  - in_ready = en & (~s1_valid | stage-1 advances).
  - Latency is 2 cycles from input accept to out_valid with out_ready held high. Full throughput is 1 per cycle.
  - result/flags stay stable while out_valid & ~out_ready. en=0 forces in_ready=0 and holds all state.
- Stage 1 (rm, sign and specials are captured with the data):
  - lsb=mant_in[3], G=mant_in[2], R|S=mant_in[1]|mant_in[0].
  - inc: RNE G&(R|S|lsb); RTZ 0; RUP ~sign&(G|R|S); RDN sign&(G|R|S).
  - inx = G|R|S.
  - sum[23:0] = {0, mant_in[25:3]} + inc. If sum[23]=1, fraction=0 and e=exp_in+1; otherwise fraction=sum[22:0] and e=exp_in.
  - e is computed EXP_W+1 bits signed, so there is no wrap.
- Stage 2, priority nan > inf > zero > overflow > underflow > normal:
  - nan: 0x7FC00000, no flags.
  - inf: {sign, 0xFF, 0}, no flags.
  - zero: {sign, 31'b0}, no flags.
  - e >= 255, overflow: flag_ovf=1, flag_inx=1. Result is signed inf for RNE, for RUP with sign=0, and for RDN with sign=1; otherwise signed max finite {sign, 0xFE, 0x7FFFFF}.
  - e <= 0, underflow: flush to {sign, 0}, flag_unf=1, flag_inx=1. No subnormal output.
  - normal: {sign, e[7:0], fraction}, flag_inx=inx.
- Simultaneous accept-in and drain-out on a full pipeline is legal and loses no data.

Test Plan:
- Pass-through: sign 0, mant_in=0x2000000, exp 127, RNE -> result 0x3FC00000 two cycles after accept, all flags 0.
- RNE ties: fraction 0x000001 with GRS=100 -> 0x3F800002, inx=1. Fraction 0x000000 with GRS=100 -> 0x3F800000, inx=1. Fraction 0x000000 with GRS=101 -> 0x3F800001.
- Rounding carry-out: fraction 0x7FFFFF, GRS=100, exp 127, RNE -> 0x40000000.
- Overflow and underflow:
  - exp 254, fraction 0x7FFFFF, GRS=111: RNE -> 0x7F800000 with ovf=1 and inx=1; RTZ -> 0x7F7FFFFF; sign 1 under RUP -> 0xFF7FFFFF.
  - exp 0 -> 0x00000000 with unf=1.
  - is_nan together with is_inf -> 0x7FC00000.
- Backpressure: 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepts and result holds the first value. Raising out_ready drains all 4 in order with no duplicate. en=0 for 3 cycles mid-stream freezes the outputs.
- Reset mid-op: drive arst_n low with both stages valid -> out_valid=0 and result=0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_round_pack.sv
// IEEE-754 single-precision rounding and packing stage: rounds a normalized
// mantissa, resolves specials/overflow/underflow, 2-stage valid/ready pipeline.
module fp_round_pack #(
    parameter int MANT_W = 26,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              is_nan,
    input  logic              is_inf,
    input  logic              is_zero,
    input  logic [1:0]        rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_inx
);

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_t;

    logic             s1_valid, s2_valid;
    logic             s1_sign, s1_inx, s1_nan, s1_inf, s1_zero;
    rm_t              s1_rm;
    logic [22:0]      s1_frac;
    logic [EXP_W:0]   s1_e;

    logic             s2_adv, s1_adv;
    logic             lsb, g, rs, inc;
    logic [23:0]      sum;
    logic [22:0]      frac_next;
    logic [EXP_W:0]   e_next;

    logic [31:0]      res_next;
    logic             ovf_next, unf_next, inx_next;
    logic             e_over, e_under, to_inf;

    assign s2_adv    = en & (~s2_valid | out_ready);
    assign s1_adv    = s1_valid & s2_adv;
    assign in_ready  = en & (~s1_valid | s1_adv);
    assign out_valid = s2_valid;

    // Stage 1: rounding increment and carry-out into the exponent
    always_comb begin
        lsb = mant_in[3];
        g   = mant_in[2];
        rs  = mant_in[1] | mant_in[0];
        unique case (rm_t'(rm))
            RM_RNE:  inc = g & (rs | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign_in & (g | rs);
            RM_RDN:  inc = sign_in & (g | rs);
            default: inc = 1'b0;
        endcase
        sum    = {1'b0, mant_in[MANT_W-1:3]} + 24'(inc);
        e_next = {exp_in[EXP_W-1], exp_in};
        if (sum[23]) begin
            frac_next = '0;
            e_next    = e_next + (EXP_W+1)'(1);
        end else begin
            frac_next = sum[22:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inx   <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_rm    <= RM_RNE;
            s1_frac  <= '0;
            s1_e     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_in;
                s1_inx  <= g | rs;
                s1_nan  <= is_nan;
                s1_inf  <= is_inf;
                s1_zero <= is_zero;
                s1_rm   <= rm_t'(rm);
                s1_frac <= frac_next;
                s1_e    <= e_next;
            end
        end
    end

    // Stage 2: exponent is signed, so range checks look at the sign bit first
    always_comb begin
        e_over   = ~s1_e[EXP_W] & (s1_e[EXP_W-1:0] >= EXP_W'(255));
        e_under  = s1_e[EXP_W] | (s1_e == '0);
        to_inf   = (s1_rm == RM_RNE) | ((s1_rm == RM_RUP) & ~s1_sign) |
                   ((s1_rm == RM_RDN) & s1_sign);
        res_next = {s1_sign, s1_e[7:0], s1_frac};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        inx_next = s1_inx;
        if (s1_nan) begin
            res_next = 32'h7FC0_0000;
            inx_next = 1'b0;
        end else if (s1_inf) begin
            res_next = {s1_sign, 8'hFF, 23'h0};
            inx_next = 1'b0;
        end else if (s1_zero) begin
            res_next = {s1_sign, 31'h0};
            inx_next = 1'b0;
        end else if (e_over) begin
            res_next = to_inf ? {s1_sign, 8'hFF, 23'h0} : {s1_sign, 8'hFE, 23'h7F_FFFF};
            ovf_next = 1'b1;
            inx_next = 1'b1;
        end else if (e_under) begin
            res_next = {s1_sign, 31'h0};
            unf_next = 1'b1;
            inx_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= res_next;
                flag_ovf <= ovf_next;
                flag_unf <= unf_next;
                flag_inx <= inx_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed rounding/special cases,
// randomized traffic against an arithmetic reference model, backpressure and reset.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        arst_n, en, in_valid, in_ready, sign_in;
    logic [25:0] mant_in;
    logic [9:0]  exp_in;
    logic        is_nan, is_inf, is_zero;
    logic [1:0]  rm;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        flag_ovf, flag_unf, flag_inx;

    int n_checks = 0;
    int n_fail   = 0;
    int n_drain  = 0;
    logic [34:0] exp_q[$];
    logic [34:0] cur_exp;

    always #5 clk = ~clk;

    fp_round_pack #(.MANT_W(26), .EXP_W(10)) dut (
        .clk(clk), .arst_n(arst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .mant_in(mant_in), .exp_in(exp_in),
        .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
    );

    // Reference: {result, ovf, unf, inx} from the rounding rules in integer arithmetic
    function automatic logic [34:0] model(input logic s, input logic [25:0] m,
                                          input logic [9:0] ex, input logic nan_i,
                                          input logic inf_i, input logic zero_i,
                                          input logic [1:0] r);
        int frac, grs, e;
        bit up, to_inf;
        frac = int'(m >> 3);
        grs  = int'(m[2:0]);
        e    = int'($signed(ex));
        if (nan_i)  return {32'h7FC00000, 3'b000};
        if (inf_i)  return {s, 8'hFF, 23'h0, 3'b000};
        if (zero_i) return {s, 31'h0, 3'b000};
        case (r)
            2'd0:    up = (grs > 4) || (grs == 4 && frac % 2 == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = !s && grs != 0;
            default: up = s && grs != 0;
        endcase
        frac += int'(up);
        if (frac == (1 << 23)) begin
            frac = 0;
            e++;
        end
        if (e >= 255) begin
            to_inf = (r == 2'd0) || (r == 2'd2 && !s) || (r == 2'd3 && s);
            return to_inf ? {s, 8'hFF, 23'h0, 3'b101} : {s, 8'hFE, 23'h7FFFFF, 3'b101};
        end
        if (e <= 0) return {s, 31'h0, 3'b011};
        return {s, 8'(e), 23'(frac), 2'b00, grs != 0};
    endfunction

    task automatic drive(input logic s, input logic [25:0] m, input logic [9:0] ex,
                         input logic nan_i, input logic inf_i, input logic zero_i,
                         input logic [1:0] r, input logic [34:0] expv, input bit use_model);
        sign_in = s; mant_in = m; exp_in = ex;
        is_nan = nan_i; is_inf = inf_i; is_zero = zero_i; rm = r;
        cur_exp = use_model ? model(s, m, ex, nan_i, inf_i, zero_i, r) : expv;
    endtask

    task automatic drive_random();
        int ex;
        ex = $urandom_range(0, 300) - 20;
        drive(1'($urandom), 26'($urandom), 10'(ex), $urandom_range(0, 31) == 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
              2'($urandom), 35'h0, 1'b1);
    endtask

    // One clock: record accepts, score drains, advance to the next falling edge
    task automatic cycle(output bit acc);
        logic [34:0] got, want;
        #1;
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(cur_exp);
        if (en && out_valid && out_ready) begin
            n_drain++;
            n_checks++;
            got = {result, flag_ovf, flag_unf, flag_inx};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL drain_unexpected: got %h, required no output", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL drain_result: got %h, required %h", got, want);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic s, input logic [25:0] m, input logic [9:0] ex,
                        input logic nan_i, input logic inf_i, input logic zero_i,
                        input logic [1:0] r, input logic [34:0] expv);
        bit acc;
        drive(s, m, ex, nan_i, inf_i, zero_i, r, expv, 1'b0);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) cycle(acc);
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d, required 1", acc);
        end
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) cycle(acc);
        cycle(acc);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, 26'h0, 10'h0, 1'b0, 1'b0, 1'b0, 2'b00, 35'h0, 1'b0);
        #3;
        n_checks++;
        if ({out_valid, result, flag_ovf, flag_unf, flag_inx} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {out_valid, result, flag_ovf, flag_unf, flag_inx});
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        send(0, 26'h2000000, 10'd127, 0, 0, 0, 2'b00, {32'h3FC00000, 3'b000});
        send(0, 26'h000000C, 10'd127, 0, 0, 0, 2'b00, {32'h3F800002, 3'b001});
        send(0, 26'h0000004, 10'd127, 0, 0, 0, 2'b00, {32'h3F800000, 3'b001});
        send(0, 26'h0000005, 10'd127, 0, 0, 0, 2'b00, {32'h3F800001, 3'b001});
        send(0, 26'h3FFFFFC, 10'd127, 0, 0, 0, 2'b00, {32'h40000000, 3'b001});
        send(0, 26'h3FFFFFF, 10'd254, 0, 0, 0, 2'b00, {32'h7F800000, 3'b101});
        send(0, 26'h3FFFFFF, 10'd254, 0, 0, 0, 2'b01, {32'h7F7FFFFF, 3'b001});
        send(1, 26'h3FFFFFF, 10'd254, 0, 0, 0, 2'b10, {32'hFF7FFFFF, 3'b001});
        send(0, 26'h0000000, 10'd300, 0, 0, 0, 2'b11, {32'h7F7FFFFF, 3'b101});
        send(0, 26'h0000000, 10'd0,   0, 0, 0, 2'b00, {32'h00000000, 3'b011});
        send(1, 26'h1234567, 10'h3FB, 0, 0, 0, 2'b00, {32'h80000000, 3'b011});
        send(0, 26'h1234567, 10'd127, 1, 1, 0, 2'b00, {32'h7FC00000, 3'b000});
        send(1, 26'h1234567, 10'd127, 0, 1, 1, 2'b00, {32'hFF800000, 3'b000});
        send(1, 26'h1234567, 10'd127, 0, 0, 1, 2'b01, {32'h80000000, 3'b000});
        drain();
    endtask

    task automatic test_random();
        bit acc;
        int n_acc = 0;
        int d0 = n_drain;
        for (int i = 0; i < 400; i++) begin
            drive_random();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc) n_acc++;
        end
        drain();
        n_checks++;
        if (n_drain - d0 != n_acc) begin
            n_fail++;
            $display("FAIL random_count: drained %0d, required %0d", n_drain - d0, n_acc);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n_acc = 0;
        int d0 = n_drain;
        logic [34:0] first;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 2 || n_acc > i - 1) drive_random();
            cycle(acc);
            if (acc) n_acc++;
        end
        first = exp_q[0];
        n_checks++;
        if (n_acc != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d accepts in_ready %b, required 2 and 0", n_acc, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || {result, flag_ovf, flag_unf, flag_inx} !== first) begin
                n_fail++;
                $display("FAIL bp_hold: got %b %h, required 1 %h", out_valid,
                         {result, flag_ovf, flag_unf, flag_inx}, first);
            end
            cycle(acc);
        end
        en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {result, flag_ovf, flag_unf, flag_inx} !== first) begin
                n_fail++;
                $display("FAIL en_freeze: got %b %b %h, required 0 1 %h", in_ready, out_valid,
                         {result, flag_ovf, flag_unf, flag_inx}, first);
            end
        end
        en = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) cycle(acc);
        drive_random();
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) cycle(acc);
        drain();
        n_checks++;
        if (n_drain - d0 != 4) begin
            n_fail++;
            $display("FAIL bp_drain_count: got %0d, required 4", n_drain - d0);
        end
    endtask

    task automatic test_reset_midop();
        bit acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_random();
        cycle(acc);
        drive_random();
        cycle(acc);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_full: got %b %b, required 1 0", out_valid, in_ready);
        end
        #2;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, result, flag_ovf, flag_unf, flag_inx} !== 36'h0) begin
            n_fail++;
            $display("FAIL midop_reset: got %h, required 0",
                     {out_valid, result, flag_ovf, flag_unf, flag_inx});
        end
        exp_q.delete();
        @(negedge clk);
        arst_n    = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_stale: got %b, required 0", out_valid);
            end
            cycle(acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
